cpu_run_ctrl: RTL

Execution controller for the multi-cycle CPU. It generates a single clock-enable, `cpu_en`, that gates every state-holding element of the datapath and the control FSM. It sequences the CPU through four modes driven by debounced button pulses: halt, single-cycle step, single-instruction step, and free run. It also provides a PC breakpoint and cycle/instruction counters for the seven-segment and LED debug displays.

---
 rtl/cpu_dbg_pkg.sv | 44 ++++
 rtl/run_prescaler.sv | 43 ++++
 rtl/cpu_run_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cpu_dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_dbg_pkg
//  Description : Shared types and constants for the CPU debug/run controller:
//                run-mode encodings, fetch-beat constant and the command
//                priority decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_dbg_pkg;

    // Run modes; the numeric values are visible on the debug display
    typedef enum logic [1:0] {
        HALT     = 2'd0,
        STEP_CYC = 2'd1,
        STEP_INS = 2'd2,
        RUN      = 2'd3
    } run_state_t;

    // Accepted command after priority resolution
    typedef enum logic [2:0] {
        CMD_NONE     = 3'd0,
        CMD_HALT     = 3'd1,
        CMD_RUN      = 3'd2,
        CMD_STEP_INS = 3'd3,
        CMD_STEP_CYC = 3'd4
    } run_cmd_t;

    // Control-FSM beat value that marks the instruction fetch
    localparam logic [4:0] BEAT_IF = 5'b00001;

    // Coincident pulses resolve as halt > run > step_ins > step_cyc
    function automatic run_cmd_t pick_cmd(input logic halt,
                                          input logic run,
                                          input logic step_ins,
                                          input logic step_cyc);
        if (halt)          return CMD_HALT;
        else if (run)      return CMD_RUN;
        else if (step_ins) return CMD_STEP_INS;
        else if (step_cyc) return CMD_STEP_CYC;
        else               return CMD_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/run_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : run_prescaler
//  Description : Free-running DIV_W-bit divider with synchronous restart.
//                Emits a one-cycle tick when the counter is about to wrap.
//                DIV_W = 0 gives a constant tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module run_prescaler #(
    parameter int DIV_W = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    generate
        if (DIV_W == 0) begin : g_div_none
            // No division: every clock is a tick
            assign tick = 1'b1;
            logic unused_ports;
            assign unused_ports = ^{clk, rst_n, restart};
        end else begin : g_div_cnt
            logic [DIV_W-1:0] r_cnt;

            // Divider counter; restart lines the first tick up 2^DIV_W clocks after entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (restart) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + DIV_W'(1);
                end
            end

            assign tick = &r_cnt;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_run_ctrl
//  Description : Execution controller for the multi-cycle CPU. Produces the
//                datapath clock enable cpu_en and sequences HALT, single-beat
//                step, single-instruction step and free run. Provides a PC
//                breakpoint and cycle/instruction counters for debug displays.
//  Options     : CPU_RUN_CTRL_BP_EN - when defined, the PC breakpoint logic
//                is built; otherwise bp_en/bp_addr/pc are ignored and bp_hit
//                is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int DIV_W = 0
) (
    input  logic             clk,
    input  logic             RSTN,
    input  logic             cmd_halt,
    input  logic             cmd_run,
    input  logic             cmd_step_ins,
    input  logic             cmd_step_cyc,
    input  logic             cnt_clr,
    input  logic [4:0]       beat,
    input  logic [31:0]      pc,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic             bp_hit,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    run_state_t       r_state;
    run_cmd_t         w_cmd;
    logic             w_fetch;
    logic             w_tick;
    logic             w_bp_cond;
    logic             w_boundary;
    logic             w_en;
    logic             r_started;
    logic             r_prev_en;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    assign w_cmd   = pick_cmd(cmd_halt, cmd_run, cmd_step_ins, cmd_step_cyc);
    assign w_fetch = (beat == BEAT_IF);

    run_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (RSTN),
        .restart (w_cmd == CMD_RUN),
        .tick    (w_tick)
    );

`ifdef CPU_RUN_CTRL_BP_EN
    logic r_skip;
    logic r_bp_hit;

    // skip masks the breakpoint until execution has moved off the resume PC
    assign w_bp_cond = bp_en && w_fetch && (pc == bp_addr) && !r_skip;

    // skip armed by run/step_ins, dropped after the first enabled cycle
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_skip <= 1'b0;
        end else if (w_cmd == CMD_RUN || w_cmd == CMD_STEP_INS) begin
            r_skip <= 1'b1;
        end else if (w_en) begin
            r_skip <= 1'b0;
        end
    end

    // Sticky breakpoint flag, cleared by any resuming command
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_bp_hit <= 1'b0;
        end else if (w_cmd == CMD_RUN || w_cmd == CMD_STEP_INS ||
                     w_cmd == CMD_STEP_CYC) begin
            r_bp_hit <= 1'b0;
        end else if (w_bp_cond && (r_state == RUN || r_state == STEP_INS)) begin
            r_bp_hit <= 1'b1;
        end
    end

    assign bp_hit = r_bp_hit;
`else
    assign w_bp_cond = 1'b0;
    assign bp_hit    = 1'b0;
    logic unused_bp;
    assign unused_bp = ^{bp_en, bp_addr, pc};
`endif

    // Instruction boundary: back at fetch after at least one enabled beat
    assign w_boundary = w_fetch && r_started;

    // Clock enable from registered mode only; commands act one clock later
    always_comb begin
        w_en = 1'b0;
        case (r_state)
            HALT:     w_en = 1'b0;
            STEP_CYC: w_en = 1'b1;
            STEP_INS: w_en = !w_boundary && !w_bp_cond;
            RUN:      w_en = w_tick && !w_bp_cond;
            default:  w_en = 1'b0;
        endcase
    end

    assign cpu_en = w_en;

    // Mode sequencer: accepted command wins, otherwise self-terminating steps
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= HALT;
        end else begin
            case (w_cmd)
                CMD_HALT:     r_state <= HALT;
                CMD_RUN:      r_state <= RUN;
                CMD_STEP_INS: r_state <= STEP_INS;
                CMD_STEP_CYC: r_state <= STEP_CYC;
                default: begin
                    case (r_state)
                        STEP_CYC: r_state <= HALT;
                        STEP_INS: if (w_boundary || w_bp_cond) r_state <= HALT;
                        RUN:      if (w_bp_cond) r_state <= HALT;
                        default:  r_state <= r_state;
                    endcase
                end
            endcase
        end
    end

    // Tracks whether the current instruction step has executed any beat
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_started <= 1'b0;
        end else if (w_cmd == CMD_STEP_INS) begin
            r_started <= 1'b0;
        end else if (w_en) begin
            r_started <= 1'b1;
        end
    end

    // Debug counters; a fetch following an enabled cycle retires an instruction
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_prev_en   <= 1'b0;
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_prev_en <= w_en;
            if (cnt_clr) begin
                r_cycle_cnt <= '0;
                r_instr_cnt <= '0;
            end else begin
                if (w_en)
                    r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
                if (w_fetch && r_prev_en)
                    r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
        end
    end

    assign state     = r_state;
    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;

endmodule
`default_nettype wire
